// File: rtl/spike_demux_pkg.sv
// Shared types and sizing helpers for the spike output demultiplexer.
// A stored spike time of GAMMA_LEN means the neuron did not fire in that slot.
package spike_demux_pkg;

  localparam int GAMMA_LEN_DEF = 8;
  localparam int NO_SPIKE      = GAMMA_LEN_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SLOT_A = 2'd1,
    SLOT_B = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Width of a stored spike time, including the no-spike code.
  function automatic int time_w(input int len);
    return $clog2(len + 1);
  endfunction

  // Width of the window cycle counter (0 .. 2*len-1).
  function automatic int cnt_w(input int len);
    return $clog2(2 * len);
  endfunction

endpackage

// File: rtl/spike_time_capture.sv
// Q-wide first-spike time latch: clr reloads the no-spike code, en admits
// the first high level per lane; clear and capture may coincide.
module spike_time_capture
  import spike_demux_pkg::*;
#(
  parameter int             Q  = 2,
  parameter int             TW = 4,
  parameter logic [TW-1:0]  NS = TW'(NO_SPIKE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [Q-1:0]          spikes_i,
  input  logic [TW-1:0]         t_i,
  output logic [Q-1:0][TW-1:0]  cap_o
);

  for (genvar g = 0; g < Q; g++) begin : g_lane
    logic [TW-1:0] cap_q, cap_d, base;

    always_comb begin
      base  = clr_i ? NS : cap_q;
      cap_d = base;
      if (en_i && spikes_i[g] && (base == NS)) cap_d = t_i;
    end

    always_ff @(posedge clk) begin
      if (rst) cap_q <= NS;
      else     cap_q <= cap_d;
    end

    assign cap_o[g] = cap_q;
  end

endmodule

// File: rtl/spike_demux.sv
// Splits each gamma window into slots A/B, captures first-spike times per
// slot, and replays both networks in parallel during the following window.
module spike_demux
  import spike_demux_pkg::*;
#(
  parameter int Q         = 2,
  parameter int GAMMA_LEN = NO_SPIKE,
  parameter int TW        = time_w(GAMMA_LEN)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         grst,
  input  logic [Q-1:0] spikes_in,
  output logic [Q-1:0] output_spikes1,
  output logic [Q-1:0] output_spikes2,
  output logic         win_valid,
  output logic         slot
);

  localparam int            CW     = cnt_w(GAMMA_LEN);
  localparam logic [TW-1:0] NS     = TW'(GAMMA_LEN);
  localparam logic [CW-1:0] T_C    = CW'(GAMMA_LEN);
  localparam logic [CW-1:0] LAST_A = CW'(GAMMA_LEN - 1);
  localparam logic [CW-1:0] LAST_B = CW'(2 * GAMMA_LEN - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          e;
  logic                   in_a, in_b, live, bv;
  logic [Q-1:0][TW-1:0]   cap_a, cap_b;
  logic [Q-1:0][TW-1:0]   rep_a_q, rep_b_q, rep_a, rep_b;
  logic                   bank_valid_q;
  logic [Q-1:0]           out1_q, out1_d, out2_q, out2_d;
  logic                   win_valid_q, win_valid_d, slot_q;

  // cnt_q is the window index of the current cycle; the grst cycle is index 0.
  assign e    = grst ? '0 : cnt_q;
  assign in_a = grst || (state_q == SLOT_A);
  assign in_b = !grst && (state_q == SLOT_B);
  assign live = grst || (state_q == SLOT_A) || (state_q == SLOT_B);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (grst) begin
      state_d = (LAST_A == '0) ? SLOT_B : SLOT_A;
      cnt_d   = CW'(1);
    end else begin
      case (state_q)
        SLOT_A: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_A) state_d = SLOT_B;
        end
        SLOT_B: begin
          if (cnt_q == LAST_B) state_d = DONE;
          else                 cnt_d   = cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  spike_time_capture #(.Q(Q), .TW(TW), .NS(NS)) u_cap_a (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (grst),
    .en_i     (in_a),
    .spikes_i (spikes_in),
    .t_i      (TW'(e)),
    .cap_o    (cap_a)
  );

  spike_time_capture #(.Q(Q), .TW(TW), .NS(NS)) u_cap_b (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (grst),
    .en_i     (in_b),
    .spikes_i (spikes_in),
    .t_i      (TW'(e - T_C)),
    .cap_o    (cap_b)
  );

  // Commit uses the pre-grst capture, which is what cap_a/cap_b still hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_a_q      <= {Q{NS}};
      rep_b_q      <= {Q{NS}};
      bank_valid_q <= 1'b0;
    end else if (grst) begin
      rep_a_q      <= cap_a;
      rep_b_q      <= cap_b;
      bank_valid_q <= 1'b1;
    end
  end

  // In the grst cycle the banks being committed drive replay at e = 0.
  assign bv    = grst || bank_valid_q;
  assign rep_a = grst ? cap_a : rep_a_q;
  assign rep_b = grst ? cap_b : rep_b_q;

  always_comb begin
    out1_d      = '0;
    out2_d      = '0;
    win_valid_d = live && bv && (e < T_C);
    for (int q = 0; q < Q; q++) begin
      out1_d[q] = win_valid_d && (rep_a[q] != NS) && (e >= CW'(rep_a[q]));
      out2_d[q] = win_valid_d && (rep_b[q] != NS) && (e >= CW'(rep_b[q]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out1_q      <= '0;
      out2_q      <= '0;
      win_valid_q <= 1'b0;
      slot_q      <= 1'b0;
    end else begin
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      win_valid_q <= win_valid_d;
      slot_q      <= (state_d == SLOT_B);
    end
  end

  assign output_spikes1 = out1_q;
  assign output_spikes2 = out2_q;
  assign win_valid      = win_valid_q;
  assign slot           = slot_q;

endmodule

// File: tb/tb_spike_demux.sv
// Scoreboard bench for spike_demux: a window-index model pushes the expected
// post-edge outputs for every driven cycle; each tick pops and compares.
module tb_spike_demux;
  localparam int Q = 2;
  localparam int T = 8;

  typedef struct packed {
    logic [Q-1:0] o1;
    logic [Q-1:0] o2;
    logic         wv;
    logic         sl;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, grst;
  logic [Q-1:0] spikes_in, output_spikes1, output_spikes2;
  logic         win_valid, slot;

  always #5 clk = ~clk;

  spike_demux #(.Q(Q), .GAMMA_LEN(T)) dut (
    .clk            (clk),
    .rst            (rst),
    .grst           (grst),
    .spikes_in      (spikes_in),
    .output_spikes1 (output_spikes1),
    .output_spikes2 (output_spikes2),
    .win_valid      (win_valid),
    .slot           (slot)
  );

  int   checks = 0, failures = 0;
  int   ca[Q], cb[Q], ta[Q], tb_t[Q];
  int   idx = -1;
  bit   bv  = 1'b0;
  exp_t sb[$];

  task automatic model_reset();
    for (int q = 0; q < Q; q++) begin
      ca[q] = T; cb[q] = T; ta[q] = T; tb_t[q] = T;
    end
    idx = -1;
    bv  = 1'b0;
  endtask

  // Drive one cycle, predict its post-edge outputs, then compare after the edge.
  task automatic tick(input logic r, input logic g, input logic [Q-1:0] s);
    exp_t ex, got;
    int   nidx;
    rst = r; grst = g; spikes_in = s;
    ex = '0;
    if (r) model_reset();
    else begin
      if (g) begin
        for (int q = 0; q < Q; q++) begin
          ta[q] = ca[q]; tb_t[q] = cb[q]; ca[q] = T; cb[q] = T;
        end
        bv  = 1'b1;
        idx = 0;
      end else if (idx >= 0 && idx < 2*T) idx++;
      for (int q = 0; q < Q; q++) begin
        if (s[q] && idx >= 0 && idx < T && ca[q] == T) ca[q] = idx;
        if (s[q] && idx >= T && idx < 2*T && cb[q] == T) cb[q] = idx - T;
      end
      ex.wv = bv && idx >= 0 && idx < T;
      for (int q = 0; q < Q; q++) begin
        ex.o1[q] = ex.wv && ta[q] != T && idx >= ta[q];
        ex.o2[q] = ex.wv && tb_t[q] != T && idx >= tb_t[q];
      end
      nidx  = (idx < 0) ? -1 : ((idx < 2*T) ? idx + 1 : 2*T);
      ex.sl = nidx >= T && nidx < 2*T;
    end
    sb.push_back(ex);
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      got = sb.pop_front();
      if (output_spikes1 !== got.o1) begin
        failures++;
        $display("FAIL out1 t=%0t got=%b exp=%b", $time, output_spikes1, got.o1);
      end
      checks++;
      if (output_spikes2 !== got.o2) begin
        failures++;
        $display("FAIL out2 t=%0t got=%b exp=%b", $time, output_spikes2, got.o2);
      end
      checks++;
      if (win_valid !== got.wv) begin
        failures++;
        $display("FAIL win_valid t=%0t got=%b exp=%b", $time, win_valid, got.wv);
      end
      checks++;
      if (slot !== got.sl) begin
        failures++;
        $display("FAIL slot t=%0t got=%b exp=%b", $time, slot, got.sl);
      end
    end
  endtask

  // Replay a window with quiet inputs; report first-rise offsets and counts.
  task automatic replay_window(output int f1, output int f2, output int nwv, output int n2);
    f1 = -1; f2 = -1; nwv = 0; n2 = 0;
    for (int i = 0; i < 2*T; i++) begin
      tick(1'b0, i == 0, '0);
      if (f1 < 0 && output_spikes1 != 0) f1 = i + 1;
      if (f2 < 0 && output_spikes2 != 0) f2 = i + 1;
      if (win_valid) nwv++;
      if (output_spikes2 != 0) n2++;
    end
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b1, 2'b11);
    checks++;
    if ({output_spikes1, output_spikes2, win_valid, slot} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {output_spikes1, output_spikes2, win_valid, slot});
    end
    tick(1'b0, 1'b0, 2'b11);
    tick(1'b0, 1'b0, '0);
  endtask

  task automatic test_basic();
    int f1, f2, nwv, n2;
    for (int i = 0; i < 2*T; i++)
      tick(1'b0, i == 0, (i >= 3 && i < 8) ? 2'b01 : ((i >= 10) ? 2'b10 : 2'b00));
    replay_window(f1, f2, nwv, n2);
    checks++;
    if (f1 !== 4) begin failures++; $display("FAIL basic_out1_rise got=%0d exp=4", f1); end
    checks++;
    if (f2 !== 3) begin failures++; $display("FAIL basic_out2_rise got=%0d exp=3", f2); end
    checks++;
    if (nwv !== T) begin failures++; $display("FAIL basic_win_valid_len got=%0d exp=%0d", nwv, T); end
  endtask

  task automatic test_straddle();
    int f1, f2, nwv, n2;
    for (int i = 0; i < 2*T; i++) tick(1'b0, i == 0, (i >= 6) ? 2'b01 : 2'b00);
    replay_window(f1, f2, nwv, n2);
    checks++;
    if (f1 !== 7) begin failures++; $display("FAIL straddle_out1_rise got=%0d exp=7", f1); end
    checks++;
    if (f2 !== 1) begin failures++; $display("FAIL straddle_out2_rise got=%0d exp=1", f2); end
  endtask

  task automatic test_early_grst();
    int f1, f2, nwv, n2;
    for (int i = 0; i < 5; i++) tick(1'b0, i == 0, (i >= 2) ? 2'b01 : 2'b00);
    replay_window(f1, f2, nwv, n2);
    checks++;
    if (f1 !== 3) begin failures++; $display("FAIL early_out1_rise got=%0d exp=3", f1); end
    checks++;
    if (n2 !== 0) begin failures++; $display("FAIL early_out2_cycles got=%0d exp=0", n2); end
  endtask

  task automatic test_same_cycle();
    int f1, f2, nwv, n2;
    for (int i = 0; i < 2*T; i++) tick(1'b0, i == 0, (i < T) ? 2'b01 : 2'b00);
    replay_window(f1, f2, nwv, n2);
    checks++;
    if (f1 !== 1) begin failures++; $display("FAIL same_cycle_rise got=%0d exp=1", f1); end
  endtask

  task automatic test_no_grst();
    tick(1'b0, 1'b1, '0);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, Q'($urandom_range(0, 3)));
    checks++;
    if (dut.state_q !== spike_demux_pkg::DONE) begin
      failures++; $display("FAIL no_grst_state got=%0d exp=%0d", dut.state_q, spike_demux_pkg::DONE);
    end
    checks++;
    if (dut.cnt_q !== 4'd15) begin
      failures++; $display("FAIL no_grst_cnt got=%0d exp=15", dut.cnt_q);
    end
    checks++;
    if ({output_spikes1, output_spikes2, win_valid} !== '0) begin
      failures++; $display("FAIL no_grst_outputs got=%b exp=0", {output_spikes1, output_spikes2, win_valid});
    end
  endtask

  task automatic test_mid_reset();
    int f1, f2, nwv, n2;
    for (int i = 0; i < 9; i++) tick(1'b0, i == 0, (i >= 2) ? 2'b11 : 2'b00);
    tick(1'b1, 1'b0, 2'b11);
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    replay_window(f1, f2, nwv, n2);
    checks++;
    if (f1 !== -1 || f2 !== -1) begin
      failures++; $display("FAIL mid_reset_replay got=%0d/%0d exp=-1/-1", f1, f2);
    end
  endtask

  task automatic test_back_to_back();
    int len, ft[Q];
    for (int w = 0; w < 8; w++) begin
      len = $urandom_range(3, 20);
      for (int q = 0; q < Q; q++) ft[q] = $urandom_range(0, len);
      for (int i = 0; i < len; i++) begin
        logic [Q-1:0] s;
        s = '0;
        for (int q = 0; q < Q; q++) s[q] = (i >= ft[q]);
        tick(1'b0, i == 0, s);
      end
    end
    for (int i = 0; i < 2*T; i++) tick(1'b0, i == 0, '0);
  endtask

  initial begin
    rst = 1'b1; grst = 1'b0; spikes_in = '0;
    model_reset();
    test_reset();
    test_basic();
    test_straddle();
    test_early_grst();
    test_same_cycle();
    test_no_grst();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_demux.md
# spike_demux

Output demultiplexer for the time-multiplexed macro column. Each gamma window (started by `grst`) is split into two equal slots: slot A carries network 1 and slot B carries network 2. The block captures the first-spike time of every column neuron in each slot. During the following window it replays both networks' spikes in parallel, each at its original relative time, on `output_spikes1` and `output_spikes2`.

## Interface
- `Q`, 2, number of column neurons.
- `GAMMA_LEN`, 8, cycles per slot (T); a full window is 2T cycles.
- `TW`, `$clog2(GAMMA_LEN+1)`, width of a stored spike time; the value T encodes "no spike".
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `grst`  in  1  window-start pulse, one cycle.
- `spikes_in`  in  Q  column output spikes; level-coded, a spike stays high once fired.
- `output_spikes1`  out  Q  replayed network-1 spikes; registered, level-coded.
- `output_spikes2`  out  Q  replayed network-2 spikes; registered, level-coded.
- `win_valid`  out  1  high while replay data for the current window is valid.
- `slot`  out  1  current capture slot: 0 = A (net 1), 1 = B (net 2).

## Operation
- **FSM states:** IDLE, SLOT_A, SLOT_B, DONE.
  - `grst` from any state → SLOT_A, cycle count cnt = 0.
  - SLOT_A → SLOT_B when cnt = T−1.
  - SLOT_B → DONE when cnt = 2T−1.
  - DONE holds until `grst`. The counter never wraps.
- **Effective time:** e = 0 in the `grst` cycle, otherwise cnt. The `grst` cycle is window cycle 0 and is sampled.
- **Capture:** two arrays, capA[Q] and capB[Q], each TW bits, initialised to T at each window start.
  - In SLOT_A (including the `grst` cycle): if `spikes_in[q]` is high and capA[q] = T, set capA[q] = e.
  - In SLOT_B: if `spikes_in[q]` is high and capB[q] = T, set capB[q] = e − T.
  - Only the first spike per slot is kept.
  - A level that is still high at the start of slot B yields capB[q] = 0. Resetting the column between slots is not this block's job.
  - IDLE and DONE ignore `spikes_in`.
- **Commit:** on `grst`, capA/capB are copied to the replay banks repA/repB and `bank_valid` is set. This happens whether or not the previous window completed, so an early `grst` commits a partial capture; neurons not yet seen commit as T.
  - `grst` while in IDLE after reset commits all-T banks.
- **Replay**, computed from window time e of the new window:
  - `output_spikes1[q]` ← `bank_valid` && repA[q] ≠ T && e < T && e ≥ repA[q].
  - `output_spikes2[q]` uses repB with the same rule.
  - Outputs are 0 for e ≥ T, in IDLE, and in DONE.
- **`win_valid`:** registered; high for window cycles 0..T−1 when `bank_valid` is set.
- **Simultaneous events:** when `grst` and a spike arrive in the same cycle, the spike is captured into the new window's capA as time 0, and the commit uses the pre-`grst` values.

## Timing
- **Reset values:** state IDLE, cnt 0, capA/capB/repA/repB all T, `bank_valid` 0, `slot` 0, all outputs 0.
- `rst` takes priority over `grst`. A reset mid-window discards captured and banked data.
- **Latency:** with `grst` at cycle c, a replayed spike at relative time t rises at cycle c+t+1 and stays high through cycle c+T. Outputs drop at c+T+1.
- Capture → output latency is one window: the commit happens at the next `grst`.
- `slot` is registered from the FSM and equals 1 exactly during SLOT_B cycles.
- No backpressure and no handshake; `grst` spacing below 2T is legal.

## Structure
- Package `spike_demux_pkg` holds:
  - the state enum: `IDLE`, `SLOT_A`, `SLOT_B`, `DONE`;
  - the `NO_SPIKE` constant (= `GAMMA_LEN`) and the time-type width function.
- Sub-module `spike_time_capture` (per slot, Q-wide first-spike latch with clear and enable) is instantiated twice. The FSM, commit, and replay logic live in the top.

## Test plan
- **Basic (T=8, Q=2):** `grst` at c0; `spikes_in` = 01 rising at e=3 and 10 rising at e=10. Next `grst` at c16 → `output_spikes1` = 01 for cycles c16+4..c16+8, `output_spikes2` = 10 for c16+3..c16+8; `win_valid` high c16+1..c16+8.
- **Straddling spike:** spike in slot A at e=6, held high into slot B → capA=6, capB=0. Replay: net1 rises at +7, net2 at +1.
- **Early `grst`:** second `grst` at e=5, spike seen at e=2 → repA=2, repB all T. `output_spikes2` stays 0; the new window starts at cnt 0.
- **Same-cycle spike:** spike concurrent with `grst` → captured as capA=0. Replays from cycle +1 of the next window.
- **No `grst`:** run 40 cycles after one `grst` → state DONE, cnt saturates at 15, spikes ignored, outputs 0.
- **Mid-window reset:** `rst` at e=9 after a capture → all outputs 0. The next `grst` replays nothing (`bank_valid` 0 until the next commit, which contains all-T).
